// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline control slice.
package pipe_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    D_WAIT = 1'b1
  } seq_state_t;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Wide enough for the largest supported data-wait limit (65535).
  localparam int unsigned WCNT_W = 16;

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count up, holding at all-ones; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: merges stall, redirect and memory-wait requests into
// per-stage write enables and flushes, with a data-wait watchdog and counters.
module pipeline_sequencer
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DWAIT_MAX = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hazard_stall,
  input  logic             ID_redirect,
  input  logic             imem_ready,
  input  logic             MEM_req,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             IF_IDFlush,
  output logic             ID_EXWrite,
  output logic             ID_EXFlush,
  output logic             EX_MEMWrite,
  output logic             MEM_WBWrite,
  output logic             MEM_WBFlush,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_dwait,
  output logic [CNT_W-1:0] cnt_redirect
);

  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(DWAIT_MAX);

  seq_state_t        state_q, state_d;
  logic              kill_q, kill_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              freeze;
  logic              inc_stall, inc_dwait, inc_redirect;

  // Freeze while a data access is outstanding and the watchdog has not expired.
  always_comb begin
    freeze = !dmem_ready &&
             (((state_q == RUN) && MEM_req) ||
              ((state_q == D_WAIT) && (wcnt_q < WAIT_LIMIT)));
  end

  // State, kill flag and wait counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      kill_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic; kill flag only moves on cycles where fetch is not held.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    wcnt_d  = wcnt_q;
    if (freeze) begin
      state_d = D_WAIT;
      wcnt_d  = wcnt_q + WCNT_W'(1);
    end else begin
      if (state_q == D_WAIT) begin
        state_d = RUN;
        wcnt_d  = '0;
      end
      if (!hazard_stall) begin
        if (kill_q && imem_ready) kill_d = 1'b0;
        if (ID_redirect && !imem_ready) kill_d = 1'b1;
      end
    end
  end

  // Stage controls and counter increments by priority: freeze, stall, kill/redirect, fetch bubble.
  always_comb begin
    PCWrite      = 1'b1;
    IF_IDWrite   = 1'b1;
    IF_IDFlush   = 1'b0;
    ID_EXWrite   = 1'b1;
    ID_EXFlush   = 1'b0;
    EX_MEMWrite  = 1'b1;
    MEM_WBWrite  = 1'b1;
    MEM_WBFlush  = 1'b0;
    inc_stall    = 1'b0;
    inc_dwait    = 1'b0;
    inc_redirect = 1'b0;
    dmem_timeout = (state_q == D_WAIT) && !dmem_ready && !freeze;
    if (freeze) begin
      PCWrite     = 1'b0;
      IF_IDWrite  = 1'b0;
      ID_EXWrite  = 1'b0;
      EX_MEMWrite = 1'b0;
      MEM_WBWrite = 1'b0;
      MEM_WBFlush = 1'b1;
      inc_dwait   = 1'b1;
    end else if (hazard_stall) begin
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXFlush = 1'b1;
      inc_stall  = 1'b1;
    end else begin
      // A stale returning fetch is discarded; a redirect in the same cycle still loads the PC.
      if (kill_q && imem_ready) begin
        PCWrite    = 1'b0;
        IF_IDFlush = 1'b1;
      end
      if (ID_redirect) begin
        PCWrite      = 1'b1;
        IF_IDFlush   = 1'b1;
        inc_redirect = 1'b1;
      end else if (!imem_ready) begin
        PCWrite    = 1'b0;
        IF_IDFlush = 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc_stall),
    .clr     (cnt_clr),
    .count   (cnt_stall)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_dwait (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc_dwait),
    .clr     (cnt_clr),
    .count   (cnt_dwait)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_redirect (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc_redirect),
    .clr     (cnt_clr),
    .count   (cnt_redirect)
  );

endmodule
